// File: rtl/mem_arbiter_ctrl.sv
// Icache/dcache arbiter in front of one RAM port, with minimum access latency.
// Define ARB_RR_EN to alternate grants under contention instead of favouring dcache.
module mem_arbiter_ctrl #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);
  localparam int CNTW = $clog2(LAT) + 1;
  localparam logic [CNTW-1:0] CMAX = CNTW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  typedef enum logic {ICACHE, DCACHE} src_t;

  state_t state, state_n;
  src_t last_src, last_src_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [31:0] last_addr, last_addr_n;
  logic fresh, fresh_n;

  logic dreq, greq, chg, done, pick_d;
  logic [31:0] gaddr;

  assign dreq  = dREN | dWEN;
  assign gaddr = (state == DGRANT) ? daddr : iaddr;
  assign greq  = (state == DGRANT) ? dreq : iREN;
  // first grant cycle compares against a stale address, so skip it
  assign chg   = !fresh && (gaddr != last_addr);
  assign done  = greq && !chg && (cnt == CMAX) && ramready;

`ifdef ARB_RR_EN
  assign pick_d = dreq && (!iREN || last_src == ICACHE);
`else
  logic src_unused;
  assign src_unused = last_src;
  assign pick_d = dreq;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      last_addr <= '0;
      last_src  <= ICACHE;
      fresh     <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_addr <= last_addr_n;
      last_src  <= last_src_n;
      fresh     <= fresh_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_addr_n = last_addr;
    last_src_n  = last_src;
    fresh_n     = fresh;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        fresh_n = 1'b1;
        if (pick_d)
          state_n = DGRANT;
        else if (iREN)
          state_n = IGRANT;
      end
      DGRANT, IGRANT: begin
        if (state == DGRANT) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dload    = ramload;
          dwait    = ~done;
        end else begin
          ramaddr  = iaddr;
          ramREN   = iREN;
          iload    = ramload;
          iwait    = ~done;
        end
        last_addr_n = gaddr;
        fresh_n     = 1'b0;
        if (!greq) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (chg) begin
          cnt_n = '0;
        end else if (done) begin
          state_n    = IDLE;
          cnt_n      = '0;
          last_src_n = (state == DGRANT) ? DCACHE : ICACHE;
        end else if (cnt != CMAX) begin
          cnt_n = cnt + CNTW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Random and directed transactions against a transaction-level arbiter model.
// Expected completions are queued by the driver and checked by a monitor.
module tb_mem_arbiter_ctrl;
  localparam int LAT = 2;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic last_d = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  assign ramload = memf(ramaddr);

  mem_arbiter_ctrl #(.LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input logic is_d, input logic wr,
                      input logic [31:0] a, input logic [31:0] st,
                      input int c);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.store = st; e.cyc = c;
    sb.push_back(e);
    last_d = is_d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0;
  endtask

  // kind: 0 icache read, 1 dcache read, 2 dcache write, 3 dcache read+write
  task automatic txn(input int kind, input logic [31:0] a,
                     input logic [31:0] st, input int stall);
    int c;
    c = cyc;
    iREN   = (kind == 0);
    dREN   = (kind == 1 || kind == 3);
    dWEN   = (kind >= 2);
    iaddr  = (kind == 0) ? a : $urandom;
    daddr  = (kind != 0) ? a : $urandom;
    dstore = st;
    ramready = 1'($urandom_range(0, 1));
    push(kind != 0, kind >= 2, a, st, c + LAT + stall);
    for (int k = 1; k <= LAT + stall; k++) begin
      tick();
      if (k < LAT) ramready = 1'($urandom_range(0, 1));
      else ramready = (k == LAT + stall);
    end
    tick();
    idle_in();
  endtask

  task automatic contend();
    int c;
    logic first_d;
    c = cyc;
    iREN = 1; dREN = 1; dWEN = 0; ramready = 1;
    iaddr = 32'h0000_1000; daddr = 32'h0000_2000; dstore = $urandom;
`ifdef ARB_RR_EN
    first_d = !last_d;
    for (int k = 0; k < 4; k++) begin
      logic d;
      d = (k % 2 == 0) ? first_d : !first_d;
      push(d, 1'b0, d ? daddr : iaddr, dstore, c + 3 * k + 2);
    end
`else
    first_d = 1'b1;
    for (int k = 0; k < 4; k++)
      push(first_d, 1'b0, daddr, dstore, c + 3 * k + 2);
`endif
    repeat (12) tick();
    idle_in();
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!iwait || !dwait) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done cyc=%0d iwait=%b dwait=%b required=none",
                 cyc, iwait, dwait);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("iwait", iwait, e.is_d);
        chk("dwait", dwait, !e.is_d);
        chk("load", e.is_d ? dload : iload, memf(e.addr));
        chk("ramaddr", ramaddr, e.addr);
        chk("ramWEN", ramWEN, e.wr);
        chk("ramREN", ramREN, !e.wr);
        if (e.wr) chk("ramstore", ramstore, e.store);
      end
    end
  end

  initial begin
    logic [31:0] a;
    nRST = 0; ramready = 1; iREN = 1; iaddr = 32'h40;
    dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    repeat (3) tick();
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    nRST = 1;
    txn(0, 32'h40, 0, 0);
    txn(3, 32'h3100, 32'h12, 0);

    for (int n = 0; n < 40; n++)
      txn($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 4));
    txn(1, 32'h500, 0, 5);

    contend();

    // withdrawn request aborts, then icache is served normally
    dREN = 1; daddr = 32'h700; ramready = 1;
    tick();
    tick();
    dREN = 0;
    tick();
    txn(0, 32'h704, 0, 0);

    // address change mid-grant restarts the latency count
    a = 32'h84;
    push(1'b1, 1'b0, a, 0, cyc + 4);
    dREN = 1; daddr = 32'h80; ramready = 1;
    tick();
    tick();
    daddr = a;
    repeat (3) tick();
    idle_in();

    // reset during an access drops strobes at once
    dREN = 1; daddr = 32'h900; ramready = 0;
    tick();
    tick();
    #2 nRST = 0;
    #1;
    chk("midrst_ramREN", ramREN, 0);
    chk("midrst_dwait", dwait, 1);
    last_d = 1'b0;
    idle_in();
    tick();
    nRST = 1;

    for (int n = 0; n < 10; n++)
      txn($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 3));
    contend();

    repeat (10) tick();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missing_done actual=none required_cycle=%0d", e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
